// File: rtl/stream_pkg.sv
// Shared widths, FSM state type and keep-mask helpers for the stream stripping datapath.
package stream_pkg;

   localparam int DEF_DATA_WD      = 32;
   localparam int DEF_DATA_BYTE_WD = DEF_DATA_WD / 8;
   localparam int MAX_BYTES        = 64;

   typedef enum logic [1:0] {
      IDLE,
      HEAD,
      STREAM,
      FLUSH
   } strip_state_t;

   // Top cnt lanes of a lanes-wide keep set; callers truncate to their own width.
   function automatic logic [MAX_BYTES-1:0] msb_keep(input int lanes, input int cnt);
      logic [MAX_BYTES-1:0] k;
      k = '0;
      for (int i = 0; i < MAX_BYTES; i++) begin
         if (i < lanes && i + cnt >= lanes) k[i] = 1'b1;
      end
      return k;
   endfunction

   function automatic logic [MAX_BYTES-1:0] lsb_keep(input int cnt);
      logic [MAX_BYTES-1:0] k;
      k = '0;
      for (int i = 0; i < MAX_BYTES; i++) begin
         if (i < cnt) k[i] = 1'b1;
      end
      return k;
   endfunction

endpackage

// File: rtl/stream_byte_merge.sv
// Byte realignment: joins the carried tail of the previous beat with the head of the
// incoming beat, and splits the incoming beat into its header part and its new carry.
module stream_byte_merge #(
   parameter int DATA_WD = 32,
   parameter int SH_WD   = 6
) (
   input  logic [DATA_WD-1:0] carry,
   input  logic [DATA_WD-1:0] data,
   input  logic [SH_WD-1:0]   carry_shift,
   input  logic [SH_WD-1:0]   data_shift,
   output logic [DATA_WD-1:0] carry_msb,
   output logic [DATA_WD-1:0] data_hi,
   output logic [DATA_WD-1:0] low_bytes,
   output logic [DATA_WD-1:0] merged
);

   // A shift equal to the full width yields zero, which covers the strip-nothing case.
   assign carry_msb = carry << carry_shift;
   assign data_hi   = data >> data_shift;
   assign low_bytes = data & ~({DATA_WD{1'b1}} << data_shift);
   assign merged    = carry_msb | data_hi;

endmodule

// File: rtl/stream_strip.sv
// Strips S leading bytes of each packet onto a header port and realigns the remaining
// payload into full MSB-first beats.
module stream_strip
   import stream_pkg::*;
#(
   parameter int DATA_WD      = DEF_DATA_WD,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_in,
   output logic                    ready_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   input  logic                    strip_valid,
   output logic                    strip_ready,
   input  logic [BYTE_CNT_WD-1:0]  strip_byte_cnt,
   output logic                    hdr_valid,
   input  logic                    hdr_ready,
   output logic [DATA_WD-1:0]      hdr_data,
   output logic [DATA_BYTE_WD-1:0] hdr_keep,
   output logic                    valid_out,
   input  logic                    ready_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out
);

   localparam int RES_WD = BYTE_CNT_WD + 1;
   localparam int SUM_WD = BYTE_CNT_WD + 2;
   localparam int SH_WD  = BYTE_CNT_WD + 4;
   localparam logic [RES_WD-1:0] FULL_R   = RES_WD'(DATA_BYTE_WD);
   localparam logic [SUM_WD-1:0] FULL_SUM = SUM_WD'(DATA_BYTE_WD);

   strip_state_t state, state_next;

   logic [BYTE_CNT_WD-1:0]  s_q;
   logic [RES_WD-1:0]       r_q, v_cnt, flush_cnt;
   logic [SUM_WD-1:0]       sum;
   logic                    fits, strip_fire, in_fire, flush_loaded, flush_load;
   logic [DATA_WD-1:0]      carry, data_m, carry_msb, data_hi, low_bytes, merged;
   logic [DATA_BYTE_WD-1:0] keep_sum, keep_flush, keep_hdr;

   // Invalid lanes of the last beat are zeroed so they never leak into carry or outputs.
   for (genvar i = 0; i < DATA_BYTE_WD; i++) begin : g_mask
      assign data_m[8*i +: 8] = data_in[8*i +: 8] & {8{keep_in[i]}};
   end

   assign v_cnt        = RES_WD'($countones(keep_in));
   assign sum          = {1'b0, r_q} + {1'b0, v_cnt};
   assign fits         = (sum <= FULL_SUM);
   assign strip_fire   = strip_valid && strip_ready;
   assign in_fire      = valid_in && ready_in;
   assign flush_loaded = valid_out && last_out;
   assign flush_load   = (state == FLUSH) && !flush_loaded && (!valid_out || ready_out);
   assign keep_sum     = DATA_BYTE_WD'(msb_keep(DATA_BYTE_WD, int'(sum)));
   assign keep_flush   = DATA_BYTE_WD'(msb_keep(DATA_BYTE_WD, int'(flush_cnt)));
   assign keep_hdr     = DATA_BYTE_WD'(lsb_keep(int'(s_q)));

   stream_byte_merge #(
      .DATA_WD (DATA_WD),
      .SH_WD   (SH_WD)
   ) u_merge (
      .carry       (carry),
      .data        (data_m),
      .carry_shift ({1'b0, s_q, 3'b000}),
      .data_shift  ({r_q, 3'b000}),
      .carry_msb   (carry_msb),
      .data_hi     (data_hi),
      .low_bytes   (low_bytes),
      .merged      (merged)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (strip_fire) state_next = HEAD;
         HEAD:    if (in_fire) state_next = last_in ? FLUSH : STREAM;
         STREAM:  if (in_fire && last_in) state_next = fits ? IDLE : FLUSH;
         FLUSH:   if (flush_loaded && ready_out) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Waiting for the payload register to drain keeps a new packet from starting
   // before the previous last beat has been taken.
   always_comb begin
      ready_in    = 1'b0;
      strip_ready = 1'b0;
      case (state)
         IDLE:    strip_ready = rst_n && !valid_out;
         HEAD:    ready_in    = !hdr_valid || hdr_ready;
         STREAM:  ready_in    = !valid_out || ready_out;
         default: ready_in    = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q       <= '0;
         r_q       <= '0;
         flush_cnt <= '0;
         carry     <= '0;
         hdr_valid <= 1'b0;
         hdr_data  <= '0;
         hdr_keep  <= '0;
         valid_out <= 1'b0;
         data_out  <= '0;
         keep_out  <= '0;
         last_out  <= 1'b0;
      end else begin
         if (hdr_valid && hdr_ready) hdr_valid <= 1'b0;
         if (valid_out && ready_out) valid_out <= 1'b0;
         case (state)
            IDLE: begin
               if (strip_fire) begin
                  s_q <= strip_byte_cnt;
                  r_q <= FULL_R - {1'b0, strip_byte_cnt};
               end
            end
            HEAD: begin
               if (in_fire) begin
                  hdr_valid <= 1'b1;
                  hdr_data  <= data_hi;
                  hdr_keep  <= keep_hdr;
                  carry     <= low_bytes;
                  flush_cnt <= v_cnt - {1'b0, s_q};
               end
            end
            STREAM: begin
               if (in_fire) begin
                  valid_out <= 1'b1;
                  data_out  <= merged;
                  carry     <= low_bytes;
                  flush_cnt <= RES_WD'(sum - FULL_SUM);
                  if (last_in && fits) begin
                     keep_out <= keep_sum;
                     last_out <= 1'b1;
                  end else begin
                     keep_out <= '1;
                     last_out <= 1'b0;
                  end
               end
            end
            FLUSH: begin
               if (flush_load) begin
                  valid_out <= 1'b1;
                  data_out  <= carry_msb;
                  keep_out  <= keep_flush;
                  last_out  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_stream_strip.sv
// Random and directed packets through stream_strip, checked against a byte-queue model
// of header extraction and payload repacking.
module tb_stream_strip;

   localparam int DW = 32;
   localparam int NB = 4;
   localparam int CW = 2;

   typedef logic [7:0] byte_q_t[$];

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          valid_in = 1'b0, ready_in;
   logic [DW-1:0] data_in = '0;
   logic [NB-1:0] keep_in = '0;
   logic          last_in = 1'b0;
   logic          strip_valid = 1'b0, strip_ready;
   logic [CW-1:0] strip_byte_cnt = '0;
   logic          hdr_valid, hdr_ready = 1'b0;
   logic [DW-1:0] hdr_data;
   logic [NB-1:0] hdr_keep;
   logic          valid_out, ready_out = 1'b0;
   logic [DW-1:0] data_out;
   logic [NB-1:0] keep_out;
   logic          last_out;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] in_data[$];
   logic [NB-1:0] in_keep[$];
   logic [DW-1:0] exp_data[$];
   logic [NB-1:0] exp_keep[$];
   logic          exp_last[$];
   logic [DW-1:0] exp_hdr_data;
   logic [NB-1:0] exp_hdr_keep;

   always #5 clk = ~clk;

   stream_strip #(
      .DATA_WD      (DW),
      .DATA_BYTE_WD (NB),
      .BYTE_CNT_WD  (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .valid_in       (valid_in),
      .ready_in       (ready_in),
      .data_in        (data_in),
      .keep_in        (keep_in),
      .last_in        (last_in),
      .strip_valid    (strip_valid),
      .strip_ready    (strip_ready),
      .strip_byte_cnt (strip_byte_cnt),
      .hdr_valid      (hdr_valid),
      .hdr_ready      (hdr_ready),
      .hdr_data       (hdr_data),
      .hdr_keep       (hdr_keep),
      .valid_out      (valid_out),
      .ready_out      (ready_out),
      .data_out       (data_out),
      .keep_out       (keep_out),
      .last_out       (last_out)
   );

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NB-1:0] msb_ones(input int n);
      logic [NB-1:0] k;
      k = '0;
      for (int i = 0; i < NB; i++) if (i >= NB - n) k[i] = 1'b1;
      return k;
   endfunction

   // The model: the first s bytes form the header, the rest is simply re-chunked into beats.
   task automatic build_packet(input int s, input byte_q_t pkt, input bit garbage);
      int nbeats, nout, plen, idx, cnt;
      logic [DW-1:0] d;
      logic [NB-1:0] k;
      in_data.delete(); in_keep.delete();
      exp_data.delete(); exp_keep.delete(); exp_last.delete();
      nbeats = (pkt.size() + NB - 1) / NB;
      for (int b = 0; b < nbeats; b++) begin
         d = '0; k = '0;
         for (int l = 0; l < NB; l++) begin
            idx = b * NB + l;
            if (idx < pkt.size()) begin
               d[DW-1-8*l -: 8] = pkt[idx];
               k[NB-1-l] = 1'b1;
            end else if (garbage) begin
               d[DW-1-8*l -: 8] = 8'($urandom);
            end
         end
         in_data.push_back(d);
         in_keep.push_back(k);
      end
      exp_hdr_data = '0;
      for (int i = 0; i < s; i++) exp_hdr_data = (exp_hdr_data << 8) | DW'(pkt[i]);
      exp_hdr_keep = NB'((1 << s) - 1);
      plen = pkt.size() - s;
      nout = (plen + NB - 1) / NB;
      for (int o = 0; o < nout; o++) begin
         d = '0; cnt = 0;
         for (int l = 0; l < NB; l++) begin
            idx = s + o * NB + l;
            if (idx < pkt.size()) begin
               d[DW-1-8*l -: 8] = pkt[idx];
               cnt++;
            end
         end
         exp_data.push_back(d);
         exp_keep.push_back(msb_ones(cnt));
         exp_last.push_back(o == nout - 1);
      end
   endtask

   // mode 0: sinks always ready; 1: random gaps and backpressure; 2: one 5-cycle payload stall.
   task automatic apply_stimulus(input int s, input int mode);
      int nin, nout;
      nin  = in_data.size();
      nout = exp_data.size();
      fork
         begin
            bit fired;
            int budget;
            @(negedge clk);
            strip_valid = 1'b1;
            strip_byte_cnt = CW'(s);
            fired = 1'b0; budget = 0;
            while (!fired && budget < 200) begin
               #1 fired = strip_ready;
               @(negedge clk);
               budget++;
            end
            strip_valid = 1'b0;
            check_output("strip_accept", 64'(fired), 64'd1);
            for (int i = 0; i < nin; i++) begin
               if (mode == 1 && $urandom_range(0, 3) == 0) begin
                  valid_in = 1'b0;
                  @(negedge clk);
               end
               valid_in = 1'b1;
               data_in  = in_data[i];
               keep_in  = in_keep[i];
               last_in  = (i == nin - 1);
               fired = 1'b0; budget = 0;
               while (!fired && budget < 200) begin
                  #1 fired = ready_in;
                  @(negedge clk);
                  budget++;
               end
               check_output("in_accept", 64'(fired), 64'd1);
            end
            valid_in = 1'b0;
            last_in  = 1'b0;
         end
         begin
            bit got;
            int budget;
            got = 1'b0; budget = 0;
            while (!got && budget < 400) begin
               @(negedge clk);
               hdr_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
               #1;
               if (hdr_valid && hdr_ready) begin
                  check_output("hdr_data", 64'(hdr_data), 64'(exp_hdr_data));
                  check_output("hdr_keep", 64'(hdr_keep), 64'(exp_hdr_keep));
                  got = 1'b1;
               end
               budget++;
            end
            check_output("hdr_seen", 64'(got), 64'd1);
         end
         begin
            int budget, idx, stall_left;
            bit stalled;
            logic [DW-1:0] pd;
            logic [NB-1:0] pk;
            logic pl;
            budget = 0; idx = 0; stall_left = 0; stalled = 1'b0;
            pd = '0; pk = '0; pl = 1'b0;
            while (idx < nout && budget < 400) begin
               @(negedge clk);
               case (mode)
                  1:       ready_out = 1'($urandom_range(0, 1));
                  2: begin
                     ready_out = (stall_left == 0);
                     if (stall_left > 0) stall_left--;
                  end
                  default: ready_out = 1'b1;
               endcase
               #1;
               if (stalled) begin
                  check_output("hold_valid", 64'(valid_out), 64'd1);
                  check_output("hold_data", 64'(data_out), 64'(pd));
                  check_output("hold_keep", 64'(keep_out), 64'(pk));
                  check_output("hold_last", 64'(last_out), 64'(pl));
               end
               if (valid_out && !ready_out) begin
                  check_output("stall_ready_in", 64'(ready_in), 64'd0);
                  stalled = 1'b1;
                  pd = data_out; pk = keep_out; pl = last_out;
               end else begin
                  stalled = 1'b0;
               end
               if (valid_out && ready_out) begin
                  check_output("out_data", 64'(data_out), 64'(exp_data[idx]));
                  check_output("out_keep", 64'(keep_out), 64'(exp_keep[idx]));
                  check_output("out_last", 64'(last_out), 64'(exp_last[idx]));
                  idx++;
                  if (mode == 2 && idx == 1) stall_left = 5;
               end
               budget++;
            end
            check_output("out_count", 64'(idx), 64'(nout));
         end
      join
      @(negedge clk);
      #1 check_output("strip_ready_idle", 64'(strip_ready), 64'd1);
   endtask

   initial begin
      byte_q_t pkt;
      int s, len;

      #12;
      check_output("rst_valid_out", 64'(valid_out), 64'd0);
      check_output("rst_hdr_valid", 64'(hdr_valid), 64'd0);
      check_output("rst_strip_ready", 64'(strip_ready), 64'd0);
      check_output("rst_ready_in", 64'(ready_in), 64'd0);
      check_output("rst_data_out", 64'(data_out), 64'd0);
      check_output("rst_keep_out", 64'(keep_out), 64'd0);
      check_output("rst_hdr_keep", 64'(hdr_keep), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check_output("idle_strip_ready", 64'(strip_ready), 64'd1);
      check_output("idle_ready_in", 64'(ready_in), 64'd0);

      pkt = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
      build_packet(2, pkt, 1'b0);
      apply_stimulus(2, 0);

      pkt = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      build_packet(1, pkt, 1'b1);
      apply_stimulus(1, 0);

      pkt = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      build_packet(3, pkt, 1'b0);
      apply_stimulus(3, 0);

      pkt = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      build_packet(0, pkt, 1'b0);
      apply_stimulus(0, 0);

      pkt = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
      build_packet(2, pkt, 1'b0);
      apply_stimulus(2, 2);

      // Reset while a payload beat is held in STREAM.
      @(negedge clk);
      strip_valid = 1'b1; strip_byte_cnt = 2'd2; hdr_ready = 1'b1; ready_out = 1'b1;
      @(negedge clk);
      strip_valid = 1'b0;
      valid_in = 1'b1; data_in = 32'hA0A1A2A3; keep_in = 4'hF; last_in = 1'b0;
      @(negedge clk);
      data_in = 32'hB0B1B2B3;
      @(negedge clk);
      valid_in = 1'b0; ready_out = 1'b0;
      #1 check_output("pre_rst_valid_out", 64'(valid_out), 64'd1);
      rst_n = 1'b0;
      #1;
      check_output("mid_rst_valid_out", 64'(valid_out), 64'd0);
      check_output("mid_rst_hdr_valid", 64'(hdr_valid), 64'd0);
      check_output("mid_rst_strip_ready", 64'(strip_ready), 64'd0);
      check_output("mid_rst_ready_in", 64'(ready_in), 64'd0);
      check_output("mid_rst_data_out", 64'(data_out), 64'd0);
      check_output("mid_rst_last_out", 64'(last_out), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ready_out = 1'b1;
      build_packet(2, pkt, 1'b0);
      apply_stimulus(2, 0);

      for (int n = 0; n < 20; n++) begin
         s = $urandom_range(0, NB - 1);
         len = $urandom_range(s + 1, s + 13);
         pkt.delete();
         for (int b = 0; b < len; b++) pkt.push_back(8'($urandom));
         build_packet(s, pkt, 1'b1);
         apply_stimulus(s, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
